// File: rtl/fem_cfg_ctrl.sv
// fem_cfg_ctrl: serial configuration controller for an RF front-end module.
//   Shifts WORD_W-bit words to the front end over csn/sclk/sdata, MSB first.
//   The SCLK half-period is DIV clk cycles. fem_en is released when a sequence
//   starts. Define FEM_CFG_PWRUP_EN to insert a PWR_WAIT-cycle settle state
//   between start and the first word.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      begin a sequence (honoured in IDLE/DONE only)
//   cfg_valid/cfg_ready        word handshake; cfg_word/cfg_last captured on accept
//   fem_csn/fem_sclk/fem_sdata serial bus to the front end
//   fem_en                     front-end enable, held from start until reset
//   busy, done                 sequence status
module fem_cfg_ctrl #(
    parameter int DIV      = 4,
    parameter int WORD_W   = 32,
    parameter int PWR_WAIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_last,
    output logic              cfg_ready,
    output logic              fem_csn,
    output logic              fem_sclk,
    output logic              fem_sdata,
    output logic              fem_en,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(2 * DIV + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(2 * DIV - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(WORD_W - 1);

`ifdef FEM_CFG_PWRUP_EN
    localparam int PW = $clog2(PWR_WAIT + 1);
    localparam logic [PW-1:0] PWR_END = PW'(PWR_WAIT - 1);
    typedef enum logic [3:0] {
        IDLE, PWRUP, LOAD, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP, DONE
    } state_t;
    logic [PW-1:0] pwr_q, pwr_d;
`else
    typedef enum logic [3:0] {
        IDLE, LOAD, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP, DONE
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              csn_q, csn_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign cfg_ready = ready_q;
    assign fem_csn   = csn_q;
    assign fem_sclk  = sclk_q;
    assign fem_sdata = sdata_q;
    assign fem_en    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // All outputs are registered: each is updated on the transition that
    // enters the state in which it takes its new value.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        word_d  = word_q;
        last_d  = last_q;
        csn_d   = csn_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        en_d    = en_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef FEM_CFG_PWRUP_EN
        pwr_d   = '0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    en_d   = 1'b1;
                    done_d = 1'b0;
                    busy_d = 1'b1;
`ifdef FEM_CFG_PWRUP_EN
                    state_d = PWRUP;
`else
                    state_d = LOAD;
                    ready_d = 1'b1;
`endif
                end
            end
`ifdef FEM_CFG_PWRUP_EN
            PWRUP: begin
                pwr_d = pwr_q + 1'b1;
                if (pwr_q == PWR_END) begin
                    pwr_d   = '0;
                    state_d = LOAD;
                    ready_d = 1'b1;
                end
            end
`endif
            LOAD: begin
                if (cfg_valid) begin
                    state_d = CS_SETUP;
                    ready_d = 1'b0;
                    word_d  = cfg_word;
                    last_d  = cfg_last;
                    bit_d   = '0;
                    csn_d   = 1'b0;
                    sdata_d = cfg_word[WORD_W-1];
                end
            end
            CS_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = SHIFT_HI;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT_HI: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_END) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == BIT_END) begin
                        state_d = CS_HOLD;
                    end else begin
                        // Next bit is presented on the falling edge, half a
                        // period before the rising edge that samples it.
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + 1'b1;
                        word_d  = word_q << 1;
                        sdata_d = word_q[WORD_W-2];
                    end
                end
            end
            CS_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    csn_d   = 1'b1;
                    sdata_d = 1'b0;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_END) begin
                    cnt_d = '0;
                    if (last_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FEM_CFG_PWRUP_EN
            pwr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            last_q  <= last_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FEM_CFG_PWRUP_EN
            pwr_q   <= pwr_d;
`endif
        end
    end
endmodule

// File: tb/tb_fem_cfg_ctrl.sv
// tb_fem_cfg_ctrl: directed bench for fem_cfg_ctrl (DIV=4/WORD_W=32 and DIV=1/WORD_W=8 instances).
module tb_fem_cfg_ctrl;
`ifdef FEM_CFG_PWRUP_EN
    localparam int RDY_LAT = 1025;
`else
    localparam int RDY_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0;
    logic [31:0] cfg_word = '0;
    logic        cfg_ready, csn, sclk, sdata, en, busy, done;
    logic        b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic [7:0]  b_word = '0;
    logic        b_ready, b_csn, b_sclk, b_sdata, b_en, b_busy, b_done;

    fem_cfg_ctrl #(.DIV(4), .WORD_W(32), .PWR_WAIT(1024)) dut_a (
        .clk(clk), .rst(rst), .start(start), .cfg_valid(cfg_valid),
        .cfg_word(cfg_word), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
        .fem_csn(csn), .fem_sclk(sclk), .fem_sdata(sdata), .fem_en(en),
        .busy(busy), .done(done));

    fem_cfg_ctrl #(.DIV(1), .WORD_W(8), .PWR_WAIT(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .cfg_valid(b_valid),
        .cfg_word(b_word), .cfg_last(b_last), .cfg_ready(b_ready),
        .fem_csn(b_csn), .fem_sclk(b_sclk), .fem_sdata(b_sdata), .fem_en(b_en),
        .busy(b_busy), .done(b_done));

    initial forever #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0;
    logic csn_p = 1'b1, sclk_p = 1'b0, done_p = 1'b0, rdy_p = 1'b0, en_p = 1'b0;
    int low_run = 0, hi_run = 0, last_low = 0, rises = 0, last_rises = 0;
    int words = 0, min_gap = 1000000, viol = 0;
    int csn_rise = 0, done_rise = 0, rdy_rise = 0, en_rise = 0;
    logic [31:0] shw = '0, last_shw = '0, sig = '0;
    logic pulse = 1'b0;
    logic b_csn_p = 1'b1, b_sclk_p = 1'b0, b_done_p = 1'b0;
    int b_low = 0, b_last_low = 0, b_rises = 0, b_last_rises = 0, b_trans = 0, b_last_trans = 0;
    int b_csn_rise = 0, b_done_rise = 0;
    logic [7:0] b_shw = '0, b_last_shw = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample both DUTs just after the edge and update waveform statistics.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (csn) begin
            if (!csn_p) begin
                last_low = low_run; last_shw = shw; last_rises = rises; csn_rise = cyc; hi_run = 0;
            end
            hi_run++;
            if (sdata || sclk) viol++;
        end else begin
            if (csn_p) begin
                words++;
                if (hi_run < min_gap) min_gap = hi_run;
                low_run = 0; shw = '0; rises = 0;
            end
            low_run++;
            if (cfg_ready) viol++;
            if (sclk && !sclk_p) begin
                shw = {shw[30:0], sdata};
                rises++;
            end
        end
        if (done && !done_p) done_rise = cyc;
        if (cfg_ready && !rdy_p) rdy_rise = cyc;
        if (en && !en_p) en_rise = cyc;
        sig = (sig * 33) ^ {25'b0, csn, sclk, sdata, cfg_ready, done, busy, en};
        csn_p = csn; sclk_p = sclk; done_p = done; rdy_p = cfg_ready; en_p = en;
        if (b_csn) begin
            if (!b_csn_p) begin
                b_last_low = b_low; b_last_shw = b_shw; b_last_rises = b_rises;
                b_last_trans = b_trans; b_csn_rise = cyc;
            end
        end else begin
            if (b_csn_p) begin
                b_low = 0; b_shw = '0; b_rises = 0; b_trans = 0;
            end
            b_low++;
            if (b_sclk != b_sclk_p) b_trans++;
            if (b_sclk && !b_sclk_p) begin
                b_shw = {b_shw[6:0], b_sdata};
                b_rises++;
            end
        end
        if (b_done && !b_done_p) b_done_rise = cyc;
        b_csn_p = b_csn; b_sclk_p = b_sclk; b_done_p = b_done;
        if (pulse) start = busy && (cyc % 3 == 0);
    endtask

    task automatic kick();
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic l, input int pre);
        int n = 0;
        while (!cfg_ready && n < 3000) begin
            step();
            n++;
        end
        chk("rdy_wait", cfg_ready, 1);
        repeat (pre) step();
        if (pre > 0) chk("load_hold", {cfg_ready, csn, sclk, busy}, 4'b1101);
        cfg_valid = 1'b1; cfg_word = w; cfg_last = l;
        step();
        cfg_valid = 1'b0; cfg_word = '0; cfg_last = 1'b0;
        chk("accept", {cfg_ready, csn}, 2'b00);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin
            step();
            n++;
        end
        chk("done_wait", done, 1);
    endtask

    task automatic three_words();
        sig = '0;
        kick();
        send_word(32'h1234_5678, 1'b0, 0);
        send_word(32'hDEAD_BEEF, 1'b0, 50);
        send_word(32'h0F0F_F0F0, 1'b1, 0);
        chk("early_done", done, 0);
        wait_done();
    endtask

    initial begin
        int n, w0;
        logic [31:0] ref_sig;
        repeat (3) step();
        chk("rst_outs", {csn, sclk, sdata, en, cfg_ready, busy, done}, 7'b1000000);
        chk("b_rst_outs", {b_csn, b_sclk, b_sdata, b_en, b_ready, b_busy, b_done}, 7'b1000000);
        rst = 1'b0;
        step();
        chk("idle_hold", {csn, en, busy}, 3'b100);

        kick();
        chk("en_lat", en_rise - start_cyc, 1);
        chk("busy_on", {busy, done}, 2'b10);
        send_word(32'hA5C3_0F12, 1'b1, 0);
        chk("rdy_lat", rdy_rise - start_cyc, RDY_LAT);
        wait_done();
        chk("csn_len", last_low, 264);
        chk("sdata_word", last_shw, 32'hA5C3_0F12);
        chk("sclk_rises", last_rises, 32);
        chk("done_lat", done_rise - csn_rise, 8);
        chk("busy_off", busy, 0);
        repeat (5) step();
        chk("done_hold", {done, en}, 2'b11);

        w0 = words;
        min_gap = 1000000;
        three_words();
        ref_sig = sig;
        chk("words3", words - w0, 3);
        chk("min_gap", min_gap, 9);
        chk("w3_word", last_shw, 32'h0F0F_F0F0);
        chk("w3_len", last_low, 264);

        w0 = words;
        pulse = 1'b1;
        three_words();
        pulse = 1'b0;
        start = 1'b0;
        chk("pulse_words", words - w0, 3);
        chk("pulse_sig", sig, ref_sig);

        kick();
        send_word(32'hFFFF_FFFF, 1'b1, 0);
        n = 0;
        while (rises < 10 && n < 2000) begin
            step();
            n++;
        end
        chk("bit10_reach", rises, 10);
        rst = 1'b1;
        step();
        chk("abort_outs", {csn, sclk, sdata, en, cfg_ready, busy, done}, 7'b1000000);
        rst = 1'b0;
        step();
        chk("idle_after", {csn, en, busy, done}, 4'b1000);
        kick();
        send_word(32'h3C5A_96E1, 1'b1, 0);
        wait_done();
        chk("re_word", last_shw, 32'h3C5A_96E1);
        chk("re_len", last_low, 264);
        chk("re_rises", last_rises, 32);
        chk("viol", viol, 0);

        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("b_en", b_en, 1);
        n = 0;
        while (!b_ready && n < 100) begin
            step();
            n++;
        end
        chk("b_rdy", b_ready, 1);
        b_valid = 1'b1; b_word = 8'h81; b_last = 1'b1;
        step();
        b_valid = 1'b0; b_word = '0; b_last = 1'b0;
        n = 0;
        while (!b_done && n < 200) begin
            step();
            n++;
        end
        chk("b_done", b_done, 1);
        chk("b_csn_len", b_last_low, 18);
        chk("b_byte", b_last_shw, 8'h81);
        chk("b_rises", b_last_rises, 8);
        chk("b_toggles", b_last_trans, 16);
        chk("b_done_lat", b_done_rise - b_csn_rise, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
